// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, memory responder states and
// the width of the memory wait-state counter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned MEMLAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DACCESS,
        IACCESS
    } memstate_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter used to time RAM wait states; holds at zero and
// flags it through `zero`.
module wait_counter
    import cpu_types_pkg::*;
#(
    parameter int unsigned W = MEMLAT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_responder.sv
// Responder for datapath instruction/data requests against a single-ported
// RAM with LAT wait states; data requests take priority over fetches.
module memory_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    output logic  ihit,
    output word_t iload,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dhit,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    output logic  busy
);

    localparam logic [MEMLAT_W-1:0] LOAD_VAL = MEMLAT_W'(LAT - 1);

    memstate_t           state, next_state;
    logic [MEMLAT_W-1:0] cnt;
    logic                cnt_zero;
    logic                take_d, take_i;

    word_t daddr_q, dstore_q, iaddr_q;
    logic  op_q;
    word_t iload_q, dload_q;

    assign take_d = (state == IDLE) && (dREN || dWEN);
    assign take_i = (state == IDLE) && !(dREN || dWEN) && iREN;

    wait_counter #(
        .W(MEMLAT_W)
    ) u_wait_counter (
        .CLK      (CLK),
        .RST      (RST),
        .load     (take_d || take_i),
        .load_val (LOAD_VAL),
        .dec      (state != IDLE),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Captured request is frozen for the whole access; load holds update on the hit edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            daddr_q  <= '0;
            dstore_q <= '0;
            op_q     <= 1'b0;
            iaddr_q  <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            if (take_d) begin
                daddr_q  <= daddr;
                dstore_q <= dstore;
                op_q     <= dWEN;
            end
            if (take_i) begin
                iaddr_q <= iaddr;
            end
            if (ihit) begin
                iload_q <= ramload;
            end
            if (dhit && !op_q) begin
                dload_q <= ramload;
            end
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iload      = iload_q;
        dload      = dload_q;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (take_d) begin
                    next_state = DACCESS;
                end else if (take_i) begin
                    next_state = IACCESS;
                end
            end
            DACCESS: begin
                ramaddr  = daddr_q;
                ramstore = dstore_q;
                ramWEN   = op_q;
                ramREN   = !op_q;
                if (cnt_zero) begin
                    dhit       = 1'b1;
                    next_state = IDLE;
                    if (!op_q) begin
                        dload = ramload;
                    end
                end
            end
            IACCESS: begin
                ramaddr = iaddr_q;
                ramREN  = 1'b1;
                if (cnt_zero) begin
                    ihit       = 1'b1;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: LAT=2 instance checked through an
// expected-hit queue, plus a LAT=1 instance checked directly.
module tb_memory_responder;
    import cpu_types_pkg::*;

    localparam int unsigned LAT = 2;

    logic  CLK = 1'b0;
    logic  RST;
    logic  iREN, dREN, dWEN;
    word_t iaddr, daddr, dstore, ramload;
    logic  ihit, dhit, ramREN, ramWEN, busy;
    word_t iload, dload, ramaddr, ramstore;

    logic  iREN1, dREN1, dWEN1;
    word_t iaddr1, daddr1, dstore1, ramload1;
    logic  ihit1, dhit1, ramREN1, ramWEN1, busy1;
    word_t iload1, dload1, ramaddr1, ramstore1;

    memory_responder #(.LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .busy(busy)
    );

    memory_responder #(.LAT(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .iREN(iREN1), .iaddr(iaddr1), .ihit(ihit1), .iload(iload1),
        .dREN(dREN1), .dWEN(dWEN1), .daddr(daddr1), .dstore(dstore1),
        .dhit(dhit1), .dload(dload1),
        .ramREN(ramREN1), .ramWEN(ramWEN1), .ramaddr(ramaddr1),
        .ramstore(ramstore1), .ramload(ramload1), .busy(busy1)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit    is_d;
        word_t data;
        int    cyc;
        int    ren_n;
        int    wen_n;
        word_t addr;
        word_t store;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;
    int   ren_acc = 0, wen_acc = 0, ok_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    task automatic chkb(input string name, input logic act, input logic expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, expv);
    endtask

    task automatic issue(input bit is_d, input word_t data, input int ren_n,
                         input int wen_n, input word_t addr, input word_t store);
        exp_t x;
        x.is_d  = is_d;
        x.data  = data;
        x.cyc   = cyc + LAT;
        x.ren_n = ren_n;
        x.wen_n = wen_n;
        x.addr  = addr;
        x.store = store;
        sbq.push_back(x);
    endtask

    task automatic wait_hit();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(ihit || dhit) && n < 20);
        if (!(ihit || dhit)) chkb("hit_timeout", ihit || dhit, 1'b1);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: accumulates RAM activity per access and checks each hit against the queue head.
    always @(negedge CLK) begin
        if (RST) begin
            ren_acc = 0;
            wen_acc = 0;
            ok_acc  = 0;
        end else begin
            if (!busy) chkb("en_in_idle", ramREN || ramWEN, 1'b0);
            if (ramREN) ren_acc++;
            if (ramWEN) wen_acc++;
            if ((ramREN || ramWEN) && sbq.size() > 0 && ramaddr == sbq[0].addr &&
                (!sbq[0].is_d || ramstore == sbq[0].store))
                ok_acc++;
            if (ihit || dhit) begin
                chkb("hit_exclusive", ihit && dhit, 1'b0);
                if (sbq.size() == 0) begin
                    chkb("unexpected_hit", ihit || dhit, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chkb("hit_kind", dhit, e.is_d);
                    chk(e.is_d ? "dload" : "iload", e.is_d ? dload : iload, e.data);
                    chk("hit_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ren_cycles", 32'(ren_acc), 32'(e.ren_n));
                    chk("wen_cycles", 32'(wen_acc), 32'(e.wen_n));
                    chk("addr_store_cycles", 32'(ok_acc), 32'(LAT));
                end
                ren_acc = 0;
                wen_acc = 0;
                ok_acc  = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        iREN = 1'b1; iaddr = 32'h40;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        ramload = 32'h8C22_0004;
        iREN1 = 1'b0; dREN1 = 1'b0; dWEN1 = 1'b0;
        iaddr1 = '0; daddr1 = '0; dstore1 = '0; ramload1 = '0;

        // Reset held two cycles with a fetch pending
        repeat (2) begin
            @(negedge CLK);
            chk("rst_ctrl", 32'({ihit, dhit, ramREN, ramWEN, busy}), 32'h0);
            chk("rst_ramaddr", ramaddr, 32'h0);
            chk("rst_ramstore", ramstore, 32'h0);
            chk("rst_iload", iload, 32'h0);
            chk("rst_dload", dload, 32'h0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        issue(1'b0, 32'h8C22_0004, LAT, 0, 32'h40, 32'h0);
        wait_hit();
        iREN = 1'b0;
        ramload = 32'h1234_5678;
        @(negedge CLK);
        chk("iload_hold", iload, 32'h8C22_0004);
        chkb("idle_after_hit", busy, 1'b0);

        // Arbitration: data first, then the held fetch
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; daddr = 32'h100; dstore = 32'h0;
        ramload = 32'hA5A5_0100;
        issue(1'b1, 32'hA5A5_0100, LAT, 0, 32'h100, 32'h0);
        wait_hit();
        dREN = 1'b0;
        ramload = 32'h2000_0044;
        issue(1'b0, 32'h2000_0044, LAT, 0, 32'h44, 32'h0);
        wait_hit();
        iREN = 1'b0;

        // Store leaves dload at the last read value
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        ramload = 32'hFFFF_0000;
        issue(1'b1, 32'hA5A5_0100, 0, LAT, 32'h200, 32'hDEAD_BEEF);
        wait_hit();
        dWEN = 1'b0;

        // dREN and dWEN together is a write
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h204; dstore = 32'h0BAD_F00D;
        ramload = 32'h1111_1111;
        issue(1'b1, 32'hA5A5_0100, 0, LAT, 32'h204, 32'h0BAD_F00D);
        wait_hit();
        dREN = 1'b0; dWEN = 1'b0;

        // Request withdrawn and inputs changed mid-access
        dREN = 1'b1; daddr = 32'h300; dstore = 32'h55;
        ramload = 32'h3333_0300;
        issue(1'b1, 32'h3333_0300, LAT, 0, 32'h300, 32'h55);
        @(posedge CLK); #1;
        dREN = 1'b0; daddr = 32'h999; dstore = 32'h77;
        wait_hit();
        ramload = 32'h0;
        @(negedge CLK);
        chk("dload_hold", dload, 32'h3333_0300);

        // One-cycle reset in the middle of an access
        @(posedge CLK); #1;
        dREN = 1'b1; daddr = 32'h400; ramload = 32'h4444_0400;
        @(posedge CLK); #1;
        RST = 1'b1; dREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_ctrl", 32'({ihit, dhit, ramREN, ramWEN, busy}), 32'h0);
        chk("abort_dload", dload, 32'h0);
        chk("abort_iload", iload, 32'h0);
        repeat (4) @(negedge CLK);
        chkb("abort_stays_idle", busy, 1'b0);

        // LAT=1 instance: hit on the cycle after the request
        @(posedge CLK); #1;
        iREN1 = 1'b1; iaddr1 = 32'h80; ramload1 = 32'hCAFE_F00D;
        @(negedge CLK);
        chkb("lat1_no_hit_idle", ihit1, 1'b0);
        @(negedge CLK);
        chkb("lat1_ihit", ihit1, 1'b1);
        chk("lat1_iload", iload1, 32'hCAFE_F00D);
        chkb("lat1_ramREN", ramREN1, 1'b1);
        @(posedge CLK); #1;
        iREN1 = 1'b0;
        @(negedge CLK);
        chkb("lat1_hit_one_cycle", ihit1, 1'b0);
        chkb("lat1_idle", busy1, 1'b0);
        @(posedge CLK); #1;
        dWEN1 = 1'b1; daddr1 = 32'h10; dstore1 = 32'h0000_BEEF;
        @(negedge CLK);
        @(negedge CLK);
        chkb("lat1_dhit", dhit1, 1'b1);
        chkb("lat1_ramWEN", ramWEN1, 1'b1);
        chk("lat1_ramaddr", ramaddr1, 32'h10);
        chk("lat1_ramstore", ramstore1, 32'h0000_BEEF);
        @(posedge CLK); #1;
        dWEN1 = 1'b0;

        repeat (2) @(negedge CLK);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Responder end of the datapath memory-request protocol. The datapath holds `iREN`, `dREN` and `dWEN` asserted until it sees a one-cycle `ihit` or `dhit`, then drops them. This block accepts those requests, arbitrates data over instruction, and runs each access against a single-ported RAM with a fixed wait-state count. It sits between the datapath's request logic and the RAM model.

## Interface
- `LAT`, default 2: RAM access cycles per transfer; legal range is 1..15.
- `CLK` in 1: the single clock; everything is on its rising edge.
- `RST` in 1: synchronous reset, active-high.
- `iREN` in 1: instruction read request; level, held until `ihit`.
- `iaddr` in 32: instruction address (`word_t`).
- `ihit` out 1: one-cycle pulse; instruction access complete.
- `iload` out 32: instruction data.
- `dREN` in 1: data read request; level, held until `dhit`.
- `dWEN` in 1: data write request; level, held until `dhit`.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dhit` out 1: one-cycle pulse; data access complete.
- `dload` out 32: data read result.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data; valid on the final access cycle.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, DACCESS and IACCESS (`memstate_t`).
- **IDLE:**
  - If `dREN|dWEN`: capture `daddr`, `dstore`, and op = write if `dWEN`, else read; load `cnt = LAT-1`; go to DACCESS.
  - Else if `iREN`: capture `iaddr`; load `cnt = LAT-1`; go to IACCESS.
  - Else stay in IDLE.
  - Data always wins; both present in the same cycle → DACCESS.
- **DACCESS:**
  - Drive `ramaddr` and `ramstore` from the captured values.
  - Drive `ramWEN = op`, `ramREN = ~op`.
  - `cnt` decrements each cycle.
  - On the cycle with `cnt==0`: assert `dhit`; on a read, `dload = ramload`; go to IDLE.
- **IACCESS:** same as DACCESS, with `ramREN=1` and `ramWEN=0`. On `cnt==0`: assert `ihit`, `iload = ramload`; go to IDLE.
- **Request inputs:** they are ignored outside IDLE. Captured values are frozen for the whole access.
- **dREN and dWEN both high:** treated as a write. `dload` is not updated.
- **Request withdrawn mid-access:** the access still completes and the hit still pulses.
- **Load outputs:** `iload` and `dload` follow `ramload` during their hit cycle. At all other times they hold the value latched at the last matching hit (a hold register updated on the hit edge).
- **`cnt` width:** 4 bits, unsigned. It never wraps, because it is reloaded on entry to an access state.

## Timing
- **Reset values:** state IDLE, `cnt=0`. All outputs are 0: `ihit`, `dhit`, `ramREN`, `ramWEN`, `busy`, `ramaddr`, `ramstore`, `iload`, `dload`, and the hold registers.
- **Reset mid-access:** at the next rising edge the access is aborted, no hit is issued, and all outputs are 0.
- **Latency:** a request seen in IDLE at edge N gives its hit during cycle N+LAT, i.e. LAT+1 cycles request-to-hit.
- **Hits:** exactly one cycle wide. `ihit` and `dhit` are never high together. Hits are decoded from registered state and `cnt`.
- **RAM enables:** high for exactly LAT cycles per access, and never in IDLE.
- **Back-to-back:** the earliest next access starts the cycle after a hit (one IDLE cycle). The requester drops its enable on the hit edge, so it cannot be re-served.
- **Priority:** under a continuous `dREN` stream an instruction fetch waits; the datapath is stalled anyway. After a `dhit`, a still-pending `iREN` is taken only if the data request has been dropped.

## Structure
- `memstate_t` (IDLE, DACCESS, IACCESS) goes in `cpu_types_pkg` next to `word_t`.
- `LAT` stays a module parameter. The counter width (4) is a package constant, `MEMLAT_W`.
- One sub-module: `wait_counter`, a loadable 4-bit down-counter with a `zero` flag, synchronous active-high reset.
- Top-level FSM, capture registers and output mux stay in `memory_responder`.

## Test plan
- **Reset:** assert RST for 2 cycles with `iREN=1` → all outputs 0 and `busy=0`; after release, `ihit` occurs LAT+1 cycles later.
- **Fetch (LAT=2):** `iREN=1`, `iaddr=0x40`, `ramload=0x8C220004` → `ramREN` high 2 cycles, `ihit` on cycle 3, `iload=0x8C220004`. Afterwards `iload` holds 0x8C220004 while `ramload` changes.
- **Arbitration:** `iREN` and `dREN` rise together, `daddr=0x100` → `dhit` first. With `dREN` dropped and `iREN` held, `ihit` comes LAT+1 cycles after `dhit`'s IDLE cycle.
- **Store:** `dWEN=1`, `daddr=0x200`, `dstore=0xDEADBEEF`, held → `ramWEN=1`, `ramaddr=0x200`, `ramstore=0xDEADBEEF` for LAT cycles; one `dhit`; `dload` unchanged.
- **Boundaries:**
  - `dREN` and `dWEN` both high → write.
  - `dREN` dropped mid-access → `dhit` still pulses.
  - `RST` one cycle mid-access → no hit, IDLE next cycle.
  - LAT=1 → hit on the cycle after the request.
